// File: rtl/pll_hdmi_cfg_seq.sv
// Avalon-MM write sequencer that loads a new M/N/C/K/BW/CP set into the HDMI PLL reconfig core.
// Optional lock supervision after START is enabled with the PLL_CFG_LOCK_WAIT_EN macro.
module pll_hdmi_cfg_seq #(
  parameter int unsigned C_INDEX      = 0,
  parameter int unsigned LOCK_TIMEOUT = 1048575
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_req,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_c0,
  input  logic [31:0] cfg_k,
  input  logic [3:0]  cfg_bw,
  input  logic [2:0]  cfg_cp,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_K,
    S_WR_BW, S_WR_CP, S_WR_START, S_WAIT, S_DONE
  } state_t;

  localparam logic [4:0] C_IDX = C_INDEX[4:0];

  state_t      state_q, state_d;
  logic [17:0] m_q, m_d, n_q, n_d, c0_q, c0_d;
  logic [31:0] k_q, k_d;
  logic [3:0]  bw_q, bw_d;
  logic [2:0]  cp_q, cp_d;
  logic        err_q, err_d;

`ifdef PLL_CFG_LOCK_WAIT_EN
  localparam logic [19:0] TIMEOUT_CNT = LOCK_TIMEOUT[19:0];

  logic        sync1_q, sync2_q;
  logic [19:0] wait_cnt_q, wait_cnt_d;
  logic        seen_low_q, seen_low_d;
  logic [4:0]  hi_cnt_q, hi_cnt_d;
  logic        lock_ok;

  // Two-flop synchroniser for the asynchronous lock indicator
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      wait_cnt_q <= '0;
      seen_low_q <= 1'b0;
      hi_cnt_q   <= '0;
    end else begin
      sync1_q    <= pll_locked;
      sync2_q    <= sync1_q;
      wait_cnt_q <= wait_cnt_d;
      seen_low_q <= seen_low_d;
      hi_cnt_q   <= hi_cnt_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = pll_locked ^ (LOCK_TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      c0_q    <= '0;
      k_q     <= '0;
      bw_q    <= '0;
      cp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      c0_q    <= c0_d;
      k_q     <= k_d;
      bw_q    <= bw_d;
      cp_q    <= cp_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    m_d            = m_q;
    n_d            = n_q;
    c0_d           = c0_q;
    k_d            = k_q;
    bw_d           = bw_q;
    cp_d           = cp_q;
    err_d          = err_q;
    done           = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_address   = 6'h00;
    mgmt_writedata = 32'h0;
`ifdef PLL_CFG_LOCK_WAIT_EN
    wait_cnt_d = '0;
    seen_low_d = 1'b0;
    hi_cnt_d   = '0;
    lock_ok    = (seen_low_q && sync2_q) || (hi_cnt_q == 5'd16);
`endif

    // Each write state holds its beat until the slave drops waitrequest
    case (state_q)
      S_IDLE: begin
        if (cfg_req) begin
          m_d     = cfg_m;
          n_d     = cfg_n;
          c0_d    = cfg_c0;
          k_d     = cfg_k;
          bw_d    = cfg_bw;
          cp_d    = cfg_cp;
          err_d   = 1'b0;
          state_d = S_WR_MODE;
        end
      end
      S_WR_MODE: begin
        mgmt_write = 1'b1;
        if (!mgmt_waitrequest) state_d = S_WR_N;
      end
      S_WR_N: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h03;
        mgmt_writedata = {14'd0, n_q};
        if (!mgmt_waitrequest) state_d = S_WR_M;
      end
      S_WR_M: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h04;
        mgmt_writedata = {14'd0, m_q};
        if (!mgmt_waitrequest) state_d = S_WR_C0;
      end
      S_WR_C0: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h05;
        mgmt_writedata = {9'd0, C_IDX, c0_q};
        if (!mgmt_waitrequest) state_d = S_WR_K;
      end
      S_WR_K: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h07;
        mgmt_writedata = k_q;
        if (!mgmt_waitrequest) state_d = S_WR_BW;
      end
      S_WR_BW: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h08;
        mgmt_writedata = {28'd0, bw_q};
        if (!mgmt_waitrequest) state_d = S_WR_CP;
      end
      S_WR_CP: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h09;
        mgmt_writedata = {29'd0, cp_q};
        if (!mgmt_waitrequest) state_d = S_WR_START;
      end
      S_WR_START: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h02;
        mgmt_writedata = 32'h1;
        if (!mgmt_waitrequest) state_d = S_WAIT;
      end
      S_WAIT: begin
`ifdef PLL_CFG_LOCK_WAIT_EN
        // Accept a fresh low-to-high lock, or a lock that stayed high for 16 cycles
        wait_cnt_d = wait_cnt_q + 20'd1;
        seen_low_d = seen_low_q | ~sync2_q;
        if (!sync2_q)               hi_cnt_d = '0;
        else if (hi_cnt_q == 5'd16) hi_cnt_d = hi_cnt_q;
        else                        hi_cnt_d = hi_cnt_q + 5'd1;
        if (lock_ok) begin
          state_d = S_DONE;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
`else
        state_d = S_DONE;
`endif
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign err  = err_q;

endmodule
